fp2int_pipe: RTL and testbench

FP2INT_PIPE -- requirements
Module: fp2int_pipe

---
 rtl/fp2int_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fp2int_pipe.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp2int_pipe.sv
// Three-stage float-to-integer converter (unpack, shift, round/negate/saturate) with a
// single shared stall. Define FP2INT_ROUND_EN to honour rnd_mode; otherwise always truncates.
module fp2int_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int INT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] float,
   input  logic                 is_signed,
   input  logic                 rnd_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [INT_W-1:0]     int_val,
   output logic                 precision_lost,
   output logic                 invalid,
   output logic                 denormal,
   output logic                 sticky_inexact,
   output logic                 sticky_invalid,
   input  logic                 clr_sticky
);

   localparam int FW   = MAN_W + 1;
   localparam int XW   = INT_W + FW;
   localparam int EW   = EXP_W + 2;
   localparam int SH_W = $clog2(INT_W + 1);

   localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [EW-1:0] E_BIG  = EW'(INT_W);
   localparam logic signed [EW-1:0] E_LO   = EW'(-1);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);

`ifdef FP2INT_ROUND_EN
   localparam logic ROUND_EN = 1'b1;
`else
   localparam logic ROUND_EN = 1'b0;
`endif

   logic advance;
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Round-nearest-even increment on the integer part; carry-out kept in the top bit.
   function automatic logic [INT_W:0] round_mag(input logic [INT_W-1:0] ip, input logic g,
                                                input logic st, input logic rnd);
      logic inc;
      inc = ROUND_EN & rnd & g & (st | ip[0]);
      return {1'b0, ip} + {{INT_W{1'b0}}, inc};
   endfunction

   // Returns {invalid, precision_lost, value}.
   function automatic logic [INT_W+1:0] saturate(input logic [INT_W:0] mag, input logic sign,
                                                 input logic sg, input logic ones,
                                                 input logic nan, input logic big,
                                                 input logic inexact);
      logic                    over;
      logic                    inv;
      logic                    pl;
      logic [INT_W:0]          lim;
      logic signed [INT_W-1:0] val;
      lim = {2'b00, {(INT_W-1){1'b1}}} + {{INT_W{1'b0}}, sign};
      if (sg) over = mag > lim;
      else    over = mag[INT_W] | (sign & (|mag));
      inv = ones | big | over;
      if (inv)       val = sg ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{nan | ~sign}};
      else if (sign) val = -$signed(mag[INT_W-1:0]);
      else           val = $signed(mag[INT_W-1:0]);
      pl = inexact & ~inv;
      return {inv, pl, val};
   endfunction

   // ---------------- stage 0: unpack ----------------
   logic [EXP_W-1:0]       exp_f;
   logic [MAN_W-1:0]       frac_f;
   logic signed [EW-1:0]   e_unb;

   always_comb begin
      exp_f  = float[EXP_W+MAN_W-1:MAN_W];
      frac_f = float[MAN_W-1:0];
      e_unb  = $signed({2'b00, exp_f}) - BIAS_S;
   end

   logic             vld_p0;
   logic             sign_p0, sg_p0, rnd_p0, ones_p0, nan_p0, big_p0, tiny_p0, den_p0;
   logic [SH_W-1:0]  sh_p0;
   logic [FW-1:0]    man_p0;

   // Exponents below -1 leave nothing but sticky bits; zero and denormals land there too.
   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         sign_p0 <= float[EXP_W+MAN_W];
         sg_p0   <= is_signed;
         rnd_p0  <= rnd_mode;
         ones_p0 <= &exp_f;
         nan_p0  <= (&exp_f) & (|frac_f);
         den_p0  <= ~(|exp_f) & (|frac_f);
         big_p0  <= e_unb >= E_BIG;
         tiny_p0 <= e_unb < E_LO;
         sh_p0   <= SH_W'(e_unb + E_ONE);
         man_p0  <= {|exp_f, frac_f};
      end
   end

   // ---------------- stage 1: shift ----------------
   logic [XW-1:0]    xs;
   always_comb xs = XW'(man_p0) << sh_p0;

   logic             vld_p1;
   logic             sign_p1, sg_p1, rnd_p1, ones_p1, nan_p1, big_p1, den_p1;
   logic [INT_W-1:0] ip_p1;
   logic             g_p1, st_p1;

   always_ff @(posedge clk) begin
      if (advance && vld_p0) begin
         sign_p1 <= sign_p0;
         sg_p1   <= sg_p0;
         rnd_p1  <= rnd_p0;
         ones_p1 <= ones_p0;
         nan_p1  <= nan_p0;
         big_p1  <= big_p0;
         den_p1  <= den_p0;
         if (tiny_p0) begin
            ip_p1 <= '0;
            g_p1  <= 1'b0;
            st_p1 <= |man_p0;
         end else begin
            ip_p1 <= xs[XW-1:FW];
            g_p1  <= xs[FW-1];
            st_p1 <= |xs[FW-2:0];
         end
      end
   end

   // ---------------- stage 2: round / negate / saturate ----------------
   logic [INT_W:0]   mag_p2;
   logic [INT_W+1:0] res_p2;

   always_comb begin
      mag_p2 = round_mag(ip_p1, g_p1, st_p1, rnd_p1);
      res_p2 = saturate(mag_p2, sign_p1, sg_p1, ones_p1, nan_p1, big_p1, g_p1 | st_p1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         out_valid <= 1'b0;
      end else if (advance) begin
         vld_p0    <= in_valid;
         vld_p1    <= vld_p0;
         out_valid <= vld_p1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         int_val        <= '0;
         precision_lost <= 1'b0;
         invalid        <= 1'b0;
         denormal       <= 1'b0;
      end else if (advance && vld_p1) begin
         int_val        <= res_p2[INT_W-1:0];
         precision_lost <= res_p2[INT_W];
         invalid        <= res_p2[INT_W+1];
         denormal       <= den_p1;
      end
   end

   // A set on the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_inexact <= 1'b0;
         sticky_invalid <= 1'b0;
      end else begin
         sticky_inexact <= (sticky_inexact & ~clr_sticky) | (out_valid & out_ready & precision_lost);
         sticky_invalid <= (sticky_invalid & ~clr_sticky) | (out_valid & out_ready & invalid);
      end
   end

endmodule

// File: tb/tb_fp2int_pipe.sv
// Scoreboard bench for fp2int_pipe at default widths, with a real-arithmetic reference model.
module tb_fp2int_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] float_w = '0;
   logic        is_signed = 1'b0;
   logic        rnd_mode = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] int_val;
   logic        precision_lost, invalid, denormal;
   logic        sticky_inexact, sticky_invalid;
   logic        clr_sticky = 1'b0;

   fp2int_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .float(float_w), .is_signed(is_signed), .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready), .int_val(int_val),
      .precision_lost(precision_lost), .invalid(invalid), .denormal(denormal),
      .sticky_inexact(sticky_inexact), .sticky_invalid(sticky_invalid),
      .clr_sticky(clr_sticky)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] iv;
      logic        pl;
      logic        inv;
      logic        den;
      logic        lat;
      logic [31:0] acc;
   } exp_t;

   typedef struct {
      logic [31:0] f;
      logic        sg;
      logic        rn;
      logic [31:0] iv;
      logic        pl;
      logic        inv;
      logic        den;
   } vec_t;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];
   logic exp_si = 1'b0;
   logic exp_sv = 1'b0;
   bit   rand_done = 1'b0;

`ifdef FP2INT_ROUND_EN
   localparam bit ROUND_EN = 1'b1;
   localparam logic [31:0] R_2P5 = 32'd2, R_3P5 = 32'd4, R_M1P5 = 32'hFFFF_FFFE;
`else
   localparam bit ROUND_EN = 1'b0;
   localparam logic [31:0] R_2P5 = 32'd2, R_3P5 = 32'd3, R_M1P5 = 32'hFFFF_FFFF;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic void timeout(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endfunction

   // Value-level conversion: scale to a real, round, then range-check the integer magnitude.
   function automatic exp_t model(input logic [31:0] f, input logic sg, input logic rn);
      exp_t        r;
      logic        s;
      int          ex;
      logic [22:0] fr;
      real         a, ipr, fp;
      longint      m;
      logic        inexact;
      r  = '0;
      s  = f[31];
      ex = int'(f[30:23]);
      fr = f[22:0];
      if (ex == 255) begin
         r.inv = 1'b1;
         r.iv  = sg ? 32'h8000_0000 : ((fr != 0 || !s) ? 32'hFFFF_FFFF : 32'h0);
         return r;
      end
      if (ex == 0) begin
         if (fr != 0) begin
            r.den = 1'b1;
            r.pl  = 1'b1;
         end
         return r;
      end
      a = 1.0 + real'(fr) / 8388608.0;
      for (int k = 0; k < ex - 127; k++) a = a * 2.0;
      for (int k = 0; k < 127 - ex; k++) a = a / 2.0;
      if (a >= 8589934592.0) begin
         r.inv = 1'b1;
         r.iv  = sg ? 32'h8000_0000 : (s ? 32'h0 : 32'hFFFF_FFFF);
         return r;
      end
      ipr     = $floor(a);
      fp      = a - ipr;
      inexact = (fp != 0.0);
      m       = longint'(ipr);
      if (ROUND_EN && rn && (fp > 0.5 || (fp == 0.5 && m[0]))) m = m + 1;
      if (sg) begin
         if (m > (s ? 64'sd2147483648 : 64'sd2147483647)) begin
            r.inv = 1'b1;
            r.iv  = 32'h8000_0000;
         end else begin
            r.iv = s ? 32'(-m) : 32'(m);
            r.pl = inexact;
         end
      end else begin
         if (s && m != 0) begin
            r.inv = 1'b1;
            r.iv  = 32'h0;
         end else if (m > 64'sd4294967295) begin
            r.inv = 1'b1;
            r.iv  = 32'hFFFF_FFFF;
         end else begin
            r.iv = 32'(m);
            r.pl = inexact;
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] rand_float();
      logic [7:0]  e;
      logic [22:0] m;
      int          sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)     e = 8'h00;
      else if (sel == 1) e = 8'hFF;
      else if (sel < 5)  e = 8'($urandom_range(100, 126));
      else               e = 8'($urandom_range(127, 161));
      m = 23'($urandom);
      if ($urandom_range(0, 3) == 0) m = m & 23'h70_0000;
      if (sel == 2) m = '0;
      return {1'($urandom), e, m};
   endfunction

   task automatic send(input logic [31:0] f, input logic sg, input logic rn, input exp_t e);
      exp_t q;
      int   waited;
      q        = e;
      waited   = 0;
      in_valid  = 1'b1;
      float_w   = f;
      is_signed = sg;
      rnd_mode  = rn;
      forever begin
         @(negedge clk);
         if (rst_n && in_ready) begin
            q.acc = cyc;
            sb.push_back(q);
            break;
         end
         waited++;
         if (waited > 200) begin
            timeout("send_accept");
            break;
         end
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_rand();
      logic [31:0] f;
      logic        sg, rn;
      f  = rand_float();
      sg = 1'($urandom);
      rn = 1'($urandom);
      send(f, sg, rn, model(f, sg, rn));
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (sb.size() != 0 && waited < 100) begin
         @(posedge clk);
         waited++;
      end
      if (sb.size() != 0) timeout("drain");
      @(posedge clk);
      #1;
   endtask

   // Monitor: samples just after the falling edge, when both DUT and driver are settled.
   initial begin
      exp_t e;
      logic hs;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            sb.delete();
            exp_si = 1'b0;
            exp_sv = 1'b0;
         end else begin
            check("sticky_inexact", sticky_inexact, exp_si);
            check("sticky_invalid", sticky_invalid, exp_sv);
            if (out_valid && !out_ready) check("in_ready_stalled", in_ready, 1'b0);
            hs = out_valid && out_ready;
            e  = '0;
            if (hs) begin
               if (sb.size() == 0) begin
                  timeout("unexpected_output");
               end else begin
                  e = sb.pop_front();
                  check("int", int_val, e.iv);
                  check("precision_lost", precision_lost, e.pl);
                  check("invalid", invalid, e.inv);
                  check("denormal", denormal, e.den);
                  if (e.lat) check("latency", cyc - int'(e.acc), 3);
               end
            end
            exp_si = (exp_si & ~clr_sticky) | (hs & e.pl);
            exp_sv = (exp_sv & ~clr_sticky) | (hs & e.inv);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        dir[$];
      vec_t        v;
      exp_t        e;
      logic [31:0] stream[6];
      int          waited;

      dir.push_back('{32'h40490FDB, 1'b1, 1'b0, 32'd3,        1'b1, 1'b0, 1'b0});
      dir.push_back('{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0});
      dir.push_back('{32'h4F000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0});
      dir.push_back('{32'h4F000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0});
      dir.push_back('{32'h40200000, 1'b1, 1'b1, R_2P5,        1'b1, 1'b0, 1'b0});
      dir.push_back('{32'h40600000, 1'b1, 1'b1, R_3P5,        1'b1, 1'b0, 1'b0});
      dir.push_back('{32'hBFC00000, 1'b1, 1'b1, R_M1P5,       1'b1, 1'b0, 1'b0});
      dir.push_back('{32'h40600000, 1'b1, 1'b0, 32'd3,        1'b1, 1'b0, 1'b0});
      dir.push_back('{32'h00000001, 1'b1, 1'b0, 32'd0,        1'b1, 1'b0, 1'b1});
      dir.push_back('{32'h7FC00000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0});
      dir.push_back('{32'h80000000, 1'b0, 1'b0, 32'd0,        1'b0, 1'b0, 1'b0});
      dir.push_back('{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
      dir.push_back('{32'hBF000000, 1'b0, 1'b1, 32'd0,        1'b1, 1'b0, 1'b0});
      dir.push_back('{32'hBF800000, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0});
      dir.push_back('{32'hFF800000, 1'b0, 1'b0, 32'd0,        1'b0, 1'b1, 1'b0});
      dir.push_back('{32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0, 1'b0});

      repeat (3) @(posedge clk);
      #1;
      check("reset_out_valid", out_valid, 1'b0);
      check("reset_int", int_val, 32'h0);
      check("reset_precision_lost", precision_lost, 1'b0);
      check("reset_invalid", invalid, 1'b0);
      check("reset_denormal", denormal, 1'b0);
      check("reset_sticky_inexact", sticky_inexact, 1'b0);
      check("reset_sticky_invalid", sticky_invalid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("in_ready_after_reset", in_ready, 1'b1);
      @(posedge clk);
      #1;

      for (int i = 0; i < dir.size(); i++) begin
         v     = dir[i];
         e     = '0;
         e.iv  = v.iv;
         e.pl  = v.pl;
         e.inv = v.inv;
         e.den = v.den;
         e.lat = (i == 0);
         send(v.f, v.sg, v.rn, e);
      end
      drain();

      // Clear on the same cycle as an invalid result handshake.
      send(32'h4F000000, 1'b1, 1'b0, model(32'h4F000000, 1'b1, 1'b0));
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (!(out_valid && invalid) && waited < 20);
      if (waited >= 20) timeout("invalid_result_wait");
      clr_sticky = 1'b1;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
      @(negedge clk);
      #3;
      check("sticky_invalid_clear_and_set", sticky_invalid, 1'b1);
      check("sticky_inexact_cleared", sticky_inexact, 1'b0);
      @(posedge clk);
      #1;

      // Six back-to-back words with a five-cycle downstream stall.
      for (int k = 0; k < 6; k++) stream[k] = 32'h3F800000 + (k << 22) + 32'h1234;
      fork
         begin
            for (int k = 0; k < 6; k++)
               send(stream[k], 1'(k & 1), 1'b1, model(stream[k], 1'(k & 1), 1'b1));
         end
         begin
            repeat (2) @(posedge clk);
            #1;
            out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      drain();

      fork
         begin
            for (int k = 0; k < 300; k++) send_rand();
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               out_ready  = ($urandom_range(0, 3) != 0);
               clr_sticky = ($urandom_range(0, 15) == 0);
            end
            out_ready  = 1'b1;
            clr_sticky = 1'b0;
         end
      join
      drain();

      // Reset while words are in flight.
      fork
         begin
            for (int k = 0; k < 8; k++) send_rand();
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            rst_n = 1'b0;
            #1;
            check("midreset_out_valid", out_valid, 1'b0);
            check("midreset_int", int_val, 32'h0);
            check("midreset_sticky_invalid", sticky_invalid, 1'b0);
            @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(negedge clk);
            check("midreset_in_ready", in_ready, 1'b1);
         end
      join
      drain();

      check("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
